// File: rtl/b2bd_share_ctrl.sv
// Shared serial binary-to-BCD converter (double-dabble, 8 steps) with round-robin arbitration.
// Optional per-channel result cache enabled by defining B2BD_SHARE_CACHE_EN.
module b2bd_share_ctrl #(
    parameter int N_CH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     req,
    input  logic [8*N_CH-1:0]   bc_in,
    output logic [N_CH-1:0]     ack,
    output logic [11:0]         bdc_out,
    output logic [2:0]          bdc_ch,
    output logic                busy
);
    localparam int CW = $clog2(N_CH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] last, gnt, gnt_r;
    logic          gnt_vld;
    int unsigned   idx;
    logic [7:0]    op, sh;
    logic [2:0]    hund;
    logic [3:0]    tens, unit;
    logic [2:0]    cnt;
    logic [3:0]    f_tens, f_unit;
    logic [11:0]   step_res;
    logic          hit;
    logic [11:0]   hit_res;

    function automatic logic [3:0] adj(input logic [3:0] x);
        return (x < 4'd5) ? x : x + 4'd3;
    endfunction

    // Round-robin: first requester found searching upward from last+1, wrapping.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            idx = (32'(last) + k) % N_CH;
            if (!gnt_vld && ((req >> idx) & N_CH'(1)) != '0) begin
                gnt_vld = 1'b1;
                gnt     = CW'(idx);
            end
        end
    end

    assign op = 8'(bc_in >> {gnt, 3'b000});

    // Hundreds bit 3 is never read after a shift, so only three bits are held.
    always_comb begin
        f_tens   = adj(tens);
        f_unit   = adj(unit);
        step_res = {hund, f_tens, f_unit, sh[7]};
    end

`ifdef B2BD_SHARE_CACHE_EN
    logic [7:0]      cache_op  [N_CH];
    logic [11:0]     cache_res [N_CH];
    logic [N_CH-1:0] cache_vld;
    logic [7:0]      op_r;

    always_comb begin
        hit     = cache_vld[gnt] && (cache_op[gnt] == op);
        hit_res = cache_res[gnt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld <= '0;
            op_r      <= '0;
        end else begin
            if (state == IDLE && gnt_vld)
                op_r <= op;
            if (state == SHIFT && cnt == 3'd7) begin
                cache_vld[gnt_r] <= 1'b1;
                cache_op[gnt_r]  <= op_r;
                cache_res[gnt_r] <= step_res;
            end
        end
    end
`else
    always_comb begin
        hit     = 1'b0;
        hit_res = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_vld) state_nxt = hit ? DONE : SHIFT;
            SHIFT:   if (cnt == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last    <= CW'(N_CH - 1);
            gnt_r   <= '0;
            sh      <= '0;
            hund    <= '0;
            tens    <= '0;
            unit    <= '0;
            cnt     <= '0;
            ack     <= '0;
            bdc_out <= '0;
            bdc_ch  <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        last  <= gnt;
                        gnt_r <= gnt;
                        sh    <= op;
                        hund  <= '0;
                        tens  <= '0;
                        unit  <= '0;
                        cnt   <= '0;
                        if (hit) begin
                            bdc_out <= hit_res;
                            bdc_ch  <= 3'(gnt);
                            ack     <= N_CH'(1) << gnt;
                        end
                    end
                end
                SHIFT: begin
                    sh   <= sh << 1;
                    hund <= step_res[10:8];
                    tens <= step_res[7:4];
                    unit <= step_res[3:0];
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        bdc_out <= step_res;
                        bdc_ch  <= 3'(gnt_r);
                        ack     <= N_CH'(1) << gnt_r;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_b2bd_share_ctrl.sv
// Self-checking bench for b2bd_share_ctrl: timeline reference model plus directed literal checks.
// Honours B2BD_SHARE_CACHE_EN when the design is built with it.
module tb_b2bd_share_ctrl;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] bc_in = '0;
    logic [N-1:0]   ack;
    logic [11:0]    bdc_out;
    logic [2:0]     bdc_ch;
    logic           busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    b2bd_share_ctrl #(.N_CH(N)) dut (
        .clk(clk), .rst(rst), .req(req), .bc_in(bc_in),
        .ack(ack), .bdc_out(bdc_out), .bdc_ch(bdc_ch), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int oh_idx(input logic [N-1:0] a);
        int r = -1;
        for (int i = 0; i < N; i++)
            if (a[i] && r < 0) r = i;
        return r;
    endfunction

    // Reference model: a grant fixes the result and the edges of ack and next grant.
    int          next_grant = 0;
    int          ack_edge = -1;
    int          m_last = N - 1;
    int          p_ch = 0;
    logic [11:0] p_res = '0;
    logic [7:0]  p_op = '0;
    logic        p_full = 1'b0;
    logic [N-1:0] e_ack = '0;
    logic [11:0] e_out = '0;
    logic [2:0]  e_ch = '0;
    logic        e_busy = 1'b0;
    logic [7:0]  c_op [N];
    logic [N-1:0] c_vld = '0;

    always @(posedge clk) begin : model
        int c;
        logic [N-1:0]   rs;
        logic [8*N-1:0] bs;
        logic           hitv;
        cyc++;
        e_ack = '0;
        if (rst) begin
            m_last     = N - 1;
            next_grant = cyc + 1;
            ack_edge   = -1;
            e_out      = '0;
            e_ch       = '0;
            c_vld      = '0;
        end else begin
            if (cyc >= next_grant && req != '0) begin
                c = -1;
                for (int k = 1; k <= N; k++) begin
                    rs = req >> ((m_last + k) % N);
                    if (c < 0 && rs[0]) c = (m_last + k) % N;
                end
                m_last = c;
                bs     = bc_in >> (8 * c);
                p_op   = bs[7:0];
                p_res  = to_bcd(int'(p_op));
                p_ch   = c;
                hitv   = 1'b0;
`ifdef B2BD_SHARE_CACHE_EN
                hitv = c_vld[c] && (c_op[c] == p_op);
`endif
                if (hitv) begin
                    ack_edge   = cyc;
                    next_grant = cyc + 2;
                    p_full     = 1'b0;
                end else begin
                    ack_edge   = cyc + 8;
                    next_grant = cyc + 10;
                    p_full     = 1'b1;
                end
            end
            if (cyc == ack_edge) begin
                e_ack = N'(1) << p_ch;
                e_out = p_res;
                e_ch  = 3'(p_ch);
                if (p_full) begin
                    c_vld[p_ch] = 1'b1;
                    c_op[p_ch]  = p_op;
                end
            end
        end
        e_busy = !rst && (cyc <= next_grant - 2);
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("ack", 32'(ack), 32'(e_ack));
            check("bdc_out", 32'(bdc_out), 32'(e_out));
            check("bdc_ch", 32'(bdc_ch), 32'(e_ch));
            check("busy", 32'(busy), 32'(e_busy));
            check("hund_hi", 32'(bdc_out[11:10]), 32'd0);
        end
    end

    task automatic wait_ack(output int lat, output int bcnt, output logic [N-1:0] a);
        lat = 0;
        bcnt = 0;
        a = '0;
        while (a == '0 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            a = ack;
        end
    endtask

    task automatic conv(input int ch, input logic [7:0] v, input logic [11:0] exp,
                        input int exp_lat, input string nm);
        int lat, bcnt;
        logic [N-1:0] a;
        @(negedge clk);
        bc_in[8*ch +: 8] = v;
        req[ch] = 1'b1;
        wait_ack(lat, bcnt, a);
        req[ch] = 1'b0;
        check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
        check({nm, "_busycnt"}, 32'(bcnt), 32'(exp_lat));
        check({nm, "_ack"}, 32'(a), 32'(N'(1) << ch));
        check({nm, "_bcd"}, 32'(bdc_out), 32'(exp));
        check({nm, "_ch"}, 32'(bdc_ch), 32'(ch));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic collect(input int cnt, output int ord[4], output int tm[4], output int got);
        int n = 0;
        got = 0;
        while (got < cnt && n < 100) begin
            @(negedge clk);
            n++;
            if (ack != '0) begin
                ord[got] = oh_idx(ack);
                tm[got] = n;
                req = req & ~ack;
                got++;
            end
        end
    endtask

    int vals[5] = '{0, 9, 99, 128, 200};
    logic [11:0] exps[5] = '{12'h000, 12'h009, 12'h099, 12'h128, 12'h200};

    initial begin
        int ord[4], tm[4], got, lat, bcnt;
        logic [N-1:0] a;
        logic any;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        conv(0, 8'd255, 12'h255, 9, "single255");

        for (int i = 0; i < 5; i++)
            conv(1, 8'(vals[i]), exps[i], 9, "boundary");

        do_reset();
        @(negedge clk);
        bc_in = 32'($urandom);
        req = '1;
        collect(4, ord, tm, got);
        check("rr_count", 32'(got), 32'd4);
        for (int i = 0; i < 4; i++) check("rr_order", 32'(ord[i]), 32'(i));
        for (int i = 1; i < 4; i++) check("rr_spacing", 32'(tm[i] - tm[i-1]), 32'd10);
        @(negedge clk);
        req = 4'b1010;
        collect(2, ord, tm, got);
        check("rr2_count", 32'(got), 32'd2);
        check("rr2_first", 32'(ord[0]), 32'd1);
        check("rr2_second", 32'(ord[1]), 32'd3);
        check("rr2_lat", 32'(tm[0]), 32'd9);
        check("rr2_spacing", 32'(tm[1] - tm[0]), 32'd10);

        @(negedge clk);
        bc_in[7:0] = 8'd37;
        req[0] = 1'b1;
        repeat (2) @(negedge clk);
        bc_in[7:0] = 8'd250;
        wait_ack(lat, bcnt, a);
        req[0] = 1'b0;
        check("opsample_lat", 32'(lat), 32'd7);
        check("opsample_bcd", 32'(bdc_out), 32'h037);

        @(negedge clk);
        bc_in[7:0] = 8'd99;
        req[0] = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_bcd", 32'(bdc_out), 32'd0);
        check("abort_ch", 32'(bdc_ch), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        any = 1'b0;
        repeat (12) begin
            @(negedge clk);
            any = any | (|ack);
        end
        check("abort_noack", 32'(any), 32'd0);
        conv(0, 8'd42, 12'h042, 9, "after_abort");

`ifdef B2BD_SHARE_CACHE_EN
        conv(2, 8'd173, 12'h173, 9, "cache_miss");
        conv(2, 8'd173, 12'h173, 1, "cache_hit");
        do_reset();
        conv(2, 8'd173, 12'h173, 9, "cache_cleared");
`else
        conv(2, 8'd173, 12'h173, 9, "repeat_first");
        conv(2, 8'd173, 12'h173, 9, "repeat_second");
`endif

        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            req = req & ~ack;
            if ($urandom_range(0, 3) == 0) req = req | N'($urandom);
            if ($urandom_range(0, 7) == 0) req = req & ~(N'(1) << $urandom_range(0, N - 1));
            for (int j = 0; j < N; j++)
                if ($urandom_range(0, 5) == 0)
                    bc_in[8*j +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom)
                                                                 : 8'($urandom_range(0, 4) * 50);
        end
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        repeat (15) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/b2bd_share_ctrl.md
# b2bd_share_ctrl

Shared serial binary-to-BCD conversion engine with a round-robin request arbiter. Up to `N_CH` requesters each present an 8-bit binary value and raise `req`. The block grants one requester at a time, runs an 8-step shift-add-3 (double-dabble) conversion, and returns the 12-bit packed BCD result with a one-cycle `ack` to the granted channel. It sits between the display/readout front-ends and the BCD digit drivers, so that several counters share one converter.

## Interface
- `N_CH`, default 4: number of requesters, legal range 2..8.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  N_CH: `req[i]` high means channel i requests a conversion.
- `bc_in`  in  8*N_CH: binary operands; channel i is at `[8i+7:8i]`.
- `ack`  out  N_CH: registered one-hot pulse, exactly one cycle, for the channel whose result is on `bdc_out`.
- `bdc_out`  out  12: result as {hundreds, tens, units}, 4 bits each. Registered; holds its value until the next completion.
- `bdc_ch`  out  3: index of the channel that produced `bdc_out`. Registered; holds.
- `busy`  out  1: high whenever state is not IDLE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - If `req` is zero, stay in IDLE.
  - Otherwise grant the first set bit searching from `last+1` upward, wrapping at `N_CH-1` to 0.
  - Set `last` to the granted index.
  - Load the shift register with `bc_in` of the granted channel and clear hundreds/tens/units.
  - Set the step counter to 0 and go to SHIFT.
- **SHIFT**, 8 steps, one per cycle:
  - Apply adjust F(x) = x<5 ? x : x+3 (4-bit) to tens and units.
  - Update {hund,tens,unit} <= {hund[2:0], F(tens), F(unit), sh[7]}, then sh <= sh<<1.
  - On step 7, also register the same result into `bdc_out`, set `bdc_ch` to the granted index, set `ack[granted]`, and go to DONE.
- **DONE**: `ack` is high for this one cycle. The next state is IDLE unconditionally; `ack` clears.
- Operand is sampled only at grant. Changes on `bc_in` afterwards have no effect on the conversion in flight.
- If `req` drops before completion, the conversion still completes and `ack` still pulses.
- Requester protocol: `req[i]` must be low in the cycle after its `ack`. If it is still high when IDLE samples it, it is treated as a new request, but at lowest priority.
- Hundreds digit never exceeds 2; the upper 2 bits of hundreds are always 0.
- Reset values:
  - state IDLE, `last` = N_CH-1, so channel 0 has first priority.
  - `ack` = 0, `bdc_out` = 0, `bdc_ch` = 0, `busy` = 0.
  - Shift/BCD registers and counter = 0; cache cleared.
- `rst` mid-conversion aborts it: no `ack` is produced and the block returns to IDLE next cycle.
- `req` bits at index ≥ `N_CH` do not exist. `bdc_ch` upper bits are 0 when `N_CH` ≤ 4.

## Timing
- `req` sampled at edge t in IDLE: grant/load happens at edge t, and SHIFT steps run at edges t+1..t+8.
- `ack` and new `bdc_out` are visible after edge t+8 for one cycle. State returns to IDLE at t+9, and the earliest next grant is t+10.
- Full-conversion throughput: one result per 10 cycles.
- Simultaneous requests are served strictly round-robin. With all `N_CH` asserted continuously, every channel is served once per `N_CH` conversions.

## Configuration
- `B2BD_SHARE_CACHE_EN` defined:
  - Per-channel cache of {last operand, last result, valid}, with valid cleared by `rst`.
  - At grant, if valid and `bc_in` equals the cached operand, skip SHIFT. At edge t, load `bdc_out` from cache, set `ack`, and go directly to DONE. Latency is 1 cycle; the next grant is at t+2.
  - Every full conversion writes the cache at completion.
- Not defined: no cache storage; every grant performs the full 8-step conversion.

## Test plan
- Single channel 0, `bc` = 255: `ack[0]` after edge t+8, `bdc_out` = 0x255, `bdc_ch` = 0, `busy` high t..t+9.
- Boundary operands 0, 9, 99, 128, 200 on channel 1: results 0x000, 0x009, 0x099, 0x128, 0x200; hundreds[3:2] always 0.
- All 4 `req` raised together and dropped on their own `ack`: service order 0,1,2,3 with `ack` pulses 10 cycles apart. Then 1 and 3 re-raised after last = 3: order 1,3.
- `bc_in[0]` changed from 37 to 250 two cycles after grant: result 0x037.
- `rst` pulsed at step 4: no `ack`, all outputs 0, state IDLE. A new request of 42 yields 0x042 with full latency.
- Build with `B2BD_SHARE_CACHE_EN`, channel 2 converts 173 twice: first `ack` at t+8, second `ack` one cycle after grant. Both results are 0x173. After `rst`, the same value takes the full latency again.
